// File: rtl/mult_pkg.sv
// Shared definitions for the iterative shift-add multiplier:
// FSM encodings and the counter-width helper.
package mult_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Wide enough to hold the full iteration count n, not just n-1.
  function automatic int cnt_width(input int n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/mult_pp_step.sv
// One RUN iteration: adds the shifted magnitude of the multiplicand into the
// accumulator once for every set bit in the current multiplier slice.
module mult_pp_step #(
  parameter int WIDTH          = 16,
  parameter int BITS_PER_CYCLE = 1,
  parameter int CNT_W          = 5
) (
  input  logic [2*WIDTH-1:0]        acc,
  input  logic [WIDTH:0]            mcand,
  input  logic [BITS_PER_CYCLE-1:0] slice,
  input  logic [CNT_W-1:0]          cnt,
  output logic [2*WIDTH-1:0]        acc_next
);

  logic [2*WIDTH-1:0] mc_ext;

  assign mc_ext = {{(WIDTH-1){1'b0}}, mcand};

  always_comb begin
    acc_next = acc;
    for (int j = 0; j < BITS_PER_CYCLE; j++) begin
      if (slice[j]) begin
        acc_next = acc_next + (mc_ext << (int'(cnt) * BITS_PER_CYCLE + j));
      end
    end
  end

endmodule

// File: rtl/seq_multiplier.sv
// Iterative signed/unsigned multiplier for MULT/MULTU with a fixed,
// data-independent latency behind a start/busy/done handshake.
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_IDLE | waiting for start; hi/lo hold the last product
// ST_RUN  | accumulating partial products, BITS_PER_CYCLE bits per cycle
// ST_FIX  | applying the sign to the magnitude product, loading hi/lo
// ST_DONE | one-cycle done pulse; a new start is accepted here as well
module seq_multiplier
  import mult_pkg::*;
#(
  parameter int WIDTH          = 16,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] multiplicand,
  input  logic [WIDTH-1:0] multiplier,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int N     = WIDTH / BITS_PER_CYCLE;
  localparam int CNT_W = cnt_width(N);
  localparam logic [WIDTH:0] ONE_W1 = (WIDTH+1)'(1);

  state_t               state_q, state_d;
  logic [2*WIDTH-1:0]   acc_q, acc_step, acc_fix;
  logic [WIDTH:0]       mcand_q, mplier_q;
  logic [CNT_W-1:0]     cnt_q;
  logic                 neg_q;
  logic                 accept;
  logic                 a_neg, b_neg;
  logic [WIDTH:0]       a_abs, b_abs;

  // Magnitudes are one bit wider so that -2^(WIDTH-1) is represented exactly.
  always_comb begin
    a_neg = is_signed & multiplicand[WIDTH-1];
    b_neg = is_signed & multiplier[WIDTH-1];
    a_abs = a_neg ? (~{1'b1, multiplicand} + ONE_W1) : {1'b0, multiplicand};
    b_abs = b_neg ? (~{1'b1, multiplier} + ONE_W1) : {1'b0, multiplier};
  end

  assign acc_fix = neg_q ? (~acc_q + (2*WIDTH)'(1)) : acc_q;

  mult_pp_step #(
    .WIDTH          (WIDTH),
    .BITS_PER_CYCLE (BITS_PER_CYCLE),
    .CNT_W          (CNT_W)
  ) u_step (
    .acc      (acc_q),
    .mcand    (mcand_q),
    .slice    (mplier_q[BITS_PER_CYCLE-1:0]),
    .cnt      (cnt_q),
    .acc_next (acc_step)
  );

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        done    = (state_q == ST_DONE);
        accept  = start;
        state_d = start ? ST_RUN : ST_IDLE;
      end
      ST_RUN: begin
        busy = 1'b1;
        if (cnt_q == CNT_W'(N - 1)) state_d = ST_FIX;
      end
      ST_FIX: begin
        busy    = 1'b1;
        state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        mcand_q  <= a_abs;
        mplier_q <= b_abs;
        neg_q    <= a_neg ^ b_neg;
        acc_q    <= '0;
        cnt_q    <= '0;
      end else if (state_q == ST_RUN) begin
        acc_q    <= acc_step;
        mplier_q <= mplier_q >> BITS_PER_CYCLE;
        cnt_q    <= cnt_q + CNT_W'(1);
      end else if (state_q == ST_FIX) begin
        acc_q <= acc_fix;
        hi    <= acc_fix[2*WIDTH-1:WIDTH];
        lo    <= acc_fix[WIDTH-1:0];
      end
    end
  end

endmodule

// File: tb/tb_seq_multiplier.sv
// Bench for seq_multiplier: a 1-bit-per-cycle and a 4-bit-per-cycle instance,
// table vectors plus hand-written handshake and reset sequences, scoreboard queues.
module tb_seq_multiplier;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // sel 0: WIDTH=16, BPC=1 ; sel 1: WIDTH=16, BPC=4
  logic        rst16, start16, sgn16, busy16, done16;
  logic [15:0] a16, b16, hi16, lo16;
  logic        rst4, start4, sgn4, busy4, done4;
  logic [15:0] a4, b4, hi4, lo4;

  seq_multiplier #(.WIDTH(16), .BITS_PER_CYCLE(1)) dut16 (
    .clk(clk), .rst(rst16), .start(start16), .is_signed(sgn16),
    .multiplicand(a16), .multiplier(b16),
    .busy(busy16), .done(done16), .hi(hi16), .lo(lo16));

  seq_multiplier #(.WIDTH(16), .BITS_PER_CYCLE(4)) dut4 (
    .clk(clk), .rst(rst4), .start(start4), .is_signed(sgn4),
    .multiplicand(a4), .multiplier(b4),
    .busy(busy4), .done(done4), .hi(hi4), .lo(lo4));

  int errors = 0;
  int checks = 0;
  logic [31:0] q16[$];
  logic [31:0] q4[$];

  typedef struct {
    logic        sgn;
    logic [15:0] a;
    logic [15:0] b;
    logic [31:0] expv;
    string       name;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, expv);
    end
  endtask

  function automatic logic [31:0] ref_prod(input logic sgn, input logic [15:0] a, input logic [15:0] b);
    logic [31:0] ea, eb;
    ea = sgn ? {{16{a[15]}}, a} : {16'h0, a};
    eb = sgn ? {{16{b[15]}}, b} : {16'h0, b};
    return ea * eb;
  endfunction

  function automatic logic get_done(input int sel);
    return (sel == 0) ? done16 : done4;
  endfunction

  function automatic logic get_busy(input int sel);
    return (sel == 0) ? busy16 : busy4;
  endfunction

  function automatic logic [31:0] get_prod(input int sel);
    return (sel == 0) ? {hi16, lo16} : {hi4, lo4};
  endfunction

  task automatic drive(input int sel, input logic st, input logic sgn,
                       input logic [15:0] a, input logic [15:0] b);
    if (sel == 0) begin start16 = st; sgn16 = sgn; a16 = a; b16 = b; end
    else          begin start4  = st; sgn4  = sgn; a4  = a; b4  = b; end
  endtask

  task automatic set_start(input int sel, input logic st);
    if (sel == 0) start16 = st; else start4 = st;
  endtask

  task automatic set_rst(input int sel, input logic r);
    if (sel == 0) rst16 = r; else rst4 = r;
  endtask

  // Called at a negedge; start is seen by the following posedge.
  task automatic launch(input int sel, input logic sgn, input logic [15:0] a,
                        input logic [15:0] b, input logic [31:0] expv, input logic push);
    drive(sel, 1'b1, sgn, a, b);
    if (push) begin
      if (sel == 0) q16.push_back(expv); else q4.push_back(expv);
    end
  endtask

  // Counts edges starting with the accepting one; optional extra start pulse
  // with junk operands at edge count pulse_at (0 = none).
  task automatic wait_done(input int sel, input string name, input int pulse_at);
    int edges = 0;
    int lat = (sel == 0) ? 18 : 6;
    logic [31:0] expv;
    forever begin
      @(negedge clk);
      edges++;
      if (edges == 1) set_start(sel, 1'b0);
      if (pulse_at != 0 && edges == pulse_at) begin
        chk({name, "_busy_at_pulse"}, {31'd0, get_busy(sel)}, 32'd1);
        drive(sel, 1'b1, 1'b1, 16'hFFFF, 16'h8000);
      end
      if (pulse_at != 0 && edges == pulse_at + 1) set_start(sel, 1'b0);
      if (get_done(sel) || edges >= 60) break;
    end
    if (!get_done(sel)) begin
      chk({name, "_timeout"}, 32'd0, 32'd1);
    end else begin
      chk({name, "_latency"}, edges, lat);
      chk({name, "_busy_in_done"}, {31'd0, get_busy(sel)}, 32'd0);
      if (sel == 0) begin
        if (q16.size() == 0) chk({name, "_sb_empty"}, 32'd1, 32'd0);
        else begin expv = q16.pop_front(); chk({name, "_prod"}, get_prod(sel), expv); end
      end else begin
        if (q4.size() == 0) chk({name, "_sb_empty"}, 32'd1, 32'd0);
        else begin expv = q4.pop_front(); chk({name, "_prod"}, get_prod(sel), expv); end
      end
    end
  endtask

  task automatic run_op(input int sel, input logic sgn, input logic [15:0] a,
                        input logic [15:0] b, input logic [31:0] expv, input string name);
    @(negedge clk);
    launch(sel, sgn, a, b, expv, 1'b1);
    wait_done(sel, name, 0);
  endtask

  initial begin
    logic saw_done;
    logic [15:0] ra, rb;
    logic rs;

    rst16 = 1'b1; rst4 = 1'b1;
    drive(0, 1'b0, 1'b0, 16'h0, 16'h0);
    drive(1, 1'b0, 1'b0, 16'h0, 16'h0);
    repeat (3) @(negedge clk);
    rst16 = 1'b0; rst4 = 1'b0;
    @(negedge clk);
    chk("reset_busy16", {31'd0, busy16}, 32'd0);
    chk("reset_done16", {31'd0, done16}, 32'd0);
    chk("reset_prod16", {hi16, lo16}, 32'd0);
    chk("reset_prod4",  {30'd0, busy4, done4} | {hi4, lo4}, 32'd0);

    vecs.push_back('{1'b0, 16'hFFFF, 16'hFFFF, 32'hFFFE_0001, "u_ffff_sq"});
    vecs.push_back('{1'b1, 16'hFFFD, 16'h0005, 32'hFFFF_FFF1, "s_m3x5"});
    vecs.push_back('{1'b0, 16'hFFFD, 16'h0005, 32'h0004_FFF1, "u_fffdx5"});
    vecs.push_back('{1'b1, 16'h8000, 16'h8000, 32'h4000_0000, "s_min_sq"});
    vecs.push_back('{1'b1, 16'h8000, 16'h0001, 32'hFFFF_8000, "s_minx1"});
    vecs.push_back('{1'b1, 16'h0000, 16'h0000, 32'h0000_0000, "s_zero"});
    vecs.push_back('{1'b1, 16'h7FFF, 16'h8000, 32'hC000_8000, "s_maxxmin"});
    foreach (vecs[i]) run_op(0, vecs[i].sgn, vecs[i].a, vecs[i].b, vecs[i].expv, vecs[i].name);
    foreach (vecs[i]) run_op(1, vecs[i].sgn, vecs[i].a, vecs[i].b, vecs[i].expv, {vecs[i].name, "_bpc4"});

    // Start while busy is ignored; start during the done cycle is accepted.
    @(negedge clk);
    launch(0, 1'b0, 16'd7, 16'd9, 32'h0000_003F, 1'b1);
    wait_done(0, "ignored_start_7x9", 5);
    launch(0, 1'b0, 16'd6, 16'd7, 32'h0000_002A, 1'b1);
    @(posedge clk); #1;
    chk("b2b_busy_after_accept", {31'd0, busy16}, 32'd1);
    chk("b2b_done_one_cycle", {31'd0, done16}, 32'd0);
    chk("b2b_prod_held", {hi16, lo16}, 32'h0000_003F);
    wait_done(0, "b2b_6x7", 0);

    // Reset in the middle of RUN aborts without a done pulse.
    @(negedge clk);
    launch(0, 1'b1, 16'h1234, 16'h8765, 32'd0, 1'b0);
    repeat (8) begin
      @(negedge clk);
      start16 = 1'b0;
    end
    rst16 = 1'b1;
    @(negedge clk);
    rst16 = 1'b0;
    chk("abort_busy", {31'd0, busy16}, 32'd0);
    chk("abort_done", {31'd0, done16}, 32'd0);
    chk("abort_prod", {hi16, lo16}, 32'd0);
    saw_done = 1'b0;
    repeat (25) begin
      @(negedge clk);
      if (done16) saw_done = 1'b1;
    end
    chk("abort_no_done", {31'd0, saw_done}, 32'd0);
    run_op(0, 1'b0, 16'd2, 16'd3, 32'h0000_0006, "after_abort_2x3");

    // Same abort on the 4-bit instance.
    @(negedge clk);
    launch(1, 1'b0, 16'hFFFF, 16'hFFFF, 32'd0, 1'b0);
    repeat (3) begin
      @(negedge clk);
      start4 = 1'b0;
    end
    set_rst(1, 1'b1);
    @(negedge clk);
    set_rst(1, 1'b0);
    chk("abort4_state", {30'd0, busy4, done4} | {hi4, lo4}, 32'd0);

    run_op(1, 1'b0, 16'd1234, 16'd5678, ref_prod(1'b0, 16'd1234, 16'd5678), "u_1234x5678_bpc4");

    for (int i = 0; i < 1000; i++) begin
      ra = 16'($urandom); rb = 16'($urandom); rs = 1'($urandom);
      run_op(1, rs, ra, rb, ref_prod(rs, ra, rb), "rand_bpc4");
    end
    for (int i = 0; i < 150; i++) begin
      ra = 16'($urandom); rb = 16'($urandom); rs = 1'($urandom);
      run_op(0, rs, ra, rb, ref_prod(rs, ra, rb), "rand_bpc1");
    end

    chk("sb16_drained", q16.size(), 32'd0);
    chk("sb4_drained",  q4.size(),  32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
